// File: rtl/led_pattern_driver_pkg.sv
// Shared encodings for the LED pattern driver: pattern modes, FSM states and per-mode seeds.
package led_pattern_driver_pkg;

    typedef enum logic [1:0] {
        ModeShiftL = 2'd0,
        ModeShiftR = 2'd1,
        ModeBounce = 2'd2,
        ModeCount  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StHold = 2'd3
    } state_e;

    localparam logic [7:0] SEED_SHIFT_L = 8'h01;
    localparam logic [7:0] SEED_SHIFT_R = 8'h80;
    localparam logic [7:0] SEED_BOUNCE  = 8'h01;
    localparam logic [7:0] SEED_COUNT   = 8'h00;

    localparam int unsigned BOUNCE_PERIOD = 14;

    function automatic logic [7:0] seed_for(mode_e m);
        logic [7:0] s;
        unique case (m)
            ModeShiftL: s = SEED_SHIFT_L;
            ModeShiftR: s = SEED_SHIFT_R;
            ModeBounce: s = SEED_BOUNCE;
            ModeCount:  s = SEED_COUNT;
            default:    s = SEED_COUNT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_pattern_step.sv
// Combinational next-pattern rule: one step of the selected mode plus its wrap indication.
module led_pattern_step
    import led_pattern_driver_pkg::*;
(
    input  mode_e      mode,
    input  logic [7:0] led,
    input  logic       dir,
    output logic [7:0] next_led,
    output logic       next_dir,
    output logic       wrap
);

    always_comb begin
        next_led = led;
        next_dir = dir;
        wrap     = 1'b0;
        unique case (mode)
            ModeShiftL: begin
                next_led = {led[6:0], led[7]};
                wrap     = (next_led == SEED_SHIFT_L);
            end
            ModeShiftR: begin
                next_led = {led[0], led[7:1]};
                wrap     = (next_led == SEED_SHIFT_R);
            end
            ModeBounce: begin
                // dir=1 moves toward bit 7; direction flips on arrival at either end.
                if (dir) begin
                    next_led = {led[6:0], 1'b0};
                    if (next_led == 8'h80) begin
                        next_dir = 1'b0;
                    end
                end else begin
                    next_led = {1'b0, led[7:1]};
                    if (next_led == 8'h01) begin
                        next_dir = 1'b1;
                        wrap     = 1'b1;
                    end
                end
            end
            ModeCount: begin
                next_led = led + 8'd1;
                wrap     = (next_led == 8'h00);
            end
            default: begin
                next_led = led;
            end
        endcase
    end

endmodule

// File: rtl/led_pattern_driver.sv
// Tick-driven 8-LED pattern engine with a valid/ready mode channel, pause/hold and a wrap pulse.
module led_pattern_driver
    import led_pattern_driver_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned CNT_W    = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                mode_valid,
    output logic                mode_ready,
    input  logic                pause,
    output logic [NUM_LEDS-1:0] led,
    output logic                wrap_pulse
);

    state_e           state_q;
    mode_e            mode_q;
    mode_e            pend_mode_q;
    logic             pending_q;
    logic             dir_q;
    logic [CNT_W-1:0] pos_q;

    logic             take_req;
    logic [7:0]       step_led;
    logic             step_dir;
    logic             step_wrap;
    logic             pos_at_end;
    logic [CNT_W-1:0] pos_next;
    logic             wrap_d;

    led_pattern_step u_step (
        .mode     (mode_q),
        .led      (led),
        .dir      (dir_q),
        .next_led (step_led),
        .next_dir (step_dir),
        .wrap     (step_wrap)
    );

    // mode_ready already encodes "no request pending" outside LOAD.
    assign take_req = mode_valid && mode_ready;

    // Bounce position within its period; must agree with the shape-based wrap.
    assign pos_at_end = (pos_q == CNT_W'(BOUNCE_PERIOD - 1));
    assign pos_next   = pos_at_end ? '0 : pos_q + CNT_W'(1);

    always_comb begin
        wrap_d = step_wrap;
        if (mode_q == ModeBounce) begin
            wrap_d = step_wrap && pos_at_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= ModeShiftL;
            pend_mode_q <= ModeShiftL;
            pending_q   <= 1'b0;
            dir_q       <= 1'b1;
            pos_q       <= '0;
            led         <= '0;
            mode_ready  <= 1'b1;
            wrap_pulse  <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    led <= '0;
                    if (take_req) begin
                        mode_q     <= mode_e'(mode);
                        mode_ready <= 1'b0;
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    led        <= seed_for(mode_q);
                    dir_q      <= 1'b1;
                    pos_q      <= '0;
                    mode_ready <= 1'b1;
                    state_q    <= StRun;
                end
                StRun: begin
                    if (pause) begin
                        state_q <= StHold;
                    end else if (en) begin
                        if (pending_q) begin
                            // A pending mode replaces this step with the new seed.
                            mode_q     <= pend_mode_q;
                            led        <= seed_for(pend_mode_q);
                            dir_q      <= 1'b1;
                            pos_q      <= '0;
                            pending_q  <= 1'b0;
                            mode_ready <= 1'b1;
                        end else begin
                            led        <= step_led;
                            dir_q      <= step_dir;
                            pos_q      <= pos_next;
                            wrap_pulse <= wrap_d;
                        end
                    end
                    if (take_req) begin
                        pending_q   <= 1'b1;
                        pend_mode_q <= mode_e'(mode);
                        mode_ready  <= 1'b0;
                    end
                end
                StHold: begin
                    if (!pause) begin
                        state_q <= StRun;
                    end
                    if (take_req) begin
                        pending_q   <= 1'b1;
                        pend_mode_q <= mode_e'(mode);
                        mode_ready  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver.
module tb_led_pattern_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       mode_valid = 1'b0;
    logic       mode_ready;
    logic       pause = 1'b0;
    logic [7:0] led;
    logic       wrap_pulse;

    int tests = 0;
    int fails = 0;

    led_pattern_driver #(
        .NUM_LEDS (8),
        .CNT_W    (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .pause      (pause),
        .led        (led),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_en();
        en = 1'b1;
        cyc();
        en = 1'b0;
    endtask

    task automatic request(input logic [1:0] m);
        mode       = m;
        mode_valid = 1'b1;
        cyc();
        mode_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] one;
        logic [7:0] bounce_tbl [15];
        int         nwrap;
        one = 8'h01;
        bounce_tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                       8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_led", 32'(led), 32'h00);
        check("rst_ready", 32'(mode_ready), 32'h1);
        check("rst_wrap", 32'(wrap_pulse), 32'h0);
        pulse_en();
        check("idle_en_ignored", 32'(led), 32'h00);

        // 1: SHIFT_L; first en lands in LOAD and is dropped
        request(2'd0);
        check("load_ready", 32'(mode_ready), 32'h0);
        pulse_en();
        check("shl_seed", 32'(led), 32'h01);
        check("shl_seed_wrap", 32'(wrap_pulse), 32'h0);
        check("run_ready", 32'(mode_ready), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            pulse_en();
            check("shl_led", 32'(led), 32'(one << (i % 8)));
            check("shl_wrap", 32'(wrap_pulse), 32'(i == 8));
        end

        // 2: BOUNCE via pending request from RUN
        request(2'd2);
        check("pend_ready", 32'(mode_ready), 32'h0);
        pulse_en();
        check("bnc_seed", 32'(led), 32'h01);
        check("bnc_seed_wrap", 32'(wrap_pulse), 32'h0);
        check("bnc_ready", 32'(mode_ready), 32'h1);
        for (int i = 0; i < 15; i++) begin
            pulse_en();
            check("bnc_led", 32'(led), 32'(bounce_tbl[i]));
            check("bnc_wrap", 32'(wrap_pulse), 32'(i == 13));
        end

        // 3: COUNT through a full 256-step period
        request(2'd3);
        pulse_en();
        check("cnt_seed", 32'(led), 32'h00);
        nwrap = 0;
        for (int i = 1; i <= 256; i++) begin
            pulse_en();
            if (wrap_pulse) nwrap++;
            if (i == 255) check("cnt_ff", 32'(led), 32'hFF);
            if (i == 256) begin
                check("cnt_00", 32'(led), 32'h00);
                check("cnt_wrap_at_00", 32'(wrap_pulse), 32'h1);
            end
        end
        check("cnt_wrap_count", 32'(nwrap), 32'd1);

        // 4: pause holds the pattern, including an en in the pausing cycle
        request(2'd0);
        pulse_en();
        pulse_en();
        pulse_en();
        check("p_pre", 32'(led), 32'h04);
        pause = 1'b1;
        pulse_en();
        check("p_same_cycle", 32'(led), 32'h04);
        for (int i = 0; i < 5; i++) begin
            pulse_en();
            check("p_hold", 32'(led), 32'h04);
        end
        pause = 1'b0;
        cyc();
        pulse_en();
        check("p_resume", 32'(led), 32'h08);

        // 5: request while RUN at 10 -> SHIFT_R seed, no wrap
        pulse_en();
        check("m5_pre", 32'(led), 32'h10);
        request(2'd1);
        check("m5_ready0", 32'(mode_ready), 32'h0);
        check("m5_no_step", 32'(led), 32'h10);
        pulse_en();
        check("m5_seed", 32'(led), 32'h80);
        check("m5_no_wrap", 32'(wrap_pulse), 32'h0);
        check("m5_ready1", 32'(mode_ready), 32'h1);
        pulse_en();
        check("m5_shr", 32'(led), 32'h40);

        // Pending request survives HOLD
        request(2'd0);
        pause = 1'b1;
        cyc();
        pulse_en();
        pause = 1'b0;
        cyc();
        check("hold_pend_ready", 32'(mode_ready), 32'h0);
        check("hold_pend_led", 32'(led), 32'h40);
        pulse_en();
        check("hold_pend_seed", 32'(led), 32'h01);
        check("hold_pend_wrap", 32'(wrap_pulse), 32'h0);
        pulse_en();
        check("hold_pend_step", 32'(led), 32'h02);

        // 6: reset mid-RUN with a pending request
        request(2'd1);
        check("r6_ready0", 32'(mode_ready), 32'h0);
        rst = 1'b1;
        en  = 1'b1;
        cyc();
        rst = 1'b0;
        en  = 1'b0;
        check("r6_led", 32'(led), 32'h00);
        check("r6_ready", 32'(mode_ready), 32'h1);
        check("r6_wrap", 32'(wrap_pulse), 32'h0);
        pulse_en();
        check("r6_idle_en", 32'(led), 32'h00);
        request(2'd3);
        pulse_en();
        pulse_en();
        check("r6_restart", 32'(led), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
